// File: rtl/crypto_pkg.sv
// Shared byte types and defaults for the 8-bit cipher datapath stages.
package crypto_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t KEY_RESET_DEFAULT = 8'h00;

    function automatic byte_t mix_byte(input byte_t dat, input byte_t key);
        return dat ^ key;
    endfunction

endpackage

// File: rtl/key_xor_stage_if.sv
// Byte stream with valid/ready handshake between cipher stages.
interface key_xor_stage_if;
    import crypto_pkg::*;

    byte_t data;
    logic  valid;
    logic  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/key_xor_stage_skid_buffer.sv
// Generic 2-entry valid/ready buffer: a main register drives the outputs, backed by one skid entry.
// Latency: 1 cycle when main is empty or draining; otherwise the byte waits in skid.
// Backpressure: in_rdy is registered and drops the cycle after skid fills.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_vld,
    input  logic             out_rdy
);

    logic [WIDTH-1:0] main_dat;
    logic [WIDTH-1:0] skid_dat;
    logic             main_vld;
    logic             skid_vld;
    logic             acc;
    logic             emit;

    assign in_rdy  = ~skid_vld;
    assign out_dat = main_dat;
    assign out_vld = main_vld;
    assign acc     = in_vld & ~skid_vld;
    assign emit    = main_vld & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dat <= '0;
            skid_dat <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            // in_rdy is low here, so only a drain of skid into main can happen
            if (emit) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end
        end else if (acc) begin
            if (!main_vld || emit) begin
                main_dat <= in_dat;
                main_vld <= 1'b1;
            end else begin
                skid_dat <= in_dat;
                skid_vld <= 1'b1;
            end
        end else if (emit) begin
            main_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/key_xor_stage.sv
// Key-mixing stage: XORs each accepted byte with the current (optionally rolling) key.
// Latency: 1 cycle from accept to output when the main entry is free or draining.
// Backpressure: 2-entry skid buffer keeps one byte/clock; plain.ready drops the cycle after skid fills.
module key_xor_stage
    import crypto_pkg::*;
#(
    parameter byte_t KEY_RESET = KEY_RESET_DEFAULT,
    parameter bit    KEY_ROLL  = 1'b1,
    parameter byte_t KEY_STEP  = 8'h01,
    parameter int    COUNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  byte_t               key_in,
    input  logic                key_load,
    key_xor_stage_if.slave      plain,
    key_xor_stage_if.master     mixed,
    output logic [COUNT_W-1:0]  byte_count
);

    byte_t key;
    byte_t mix_dat;
    byte_t buf_dat;
    logic  buf_in_vld;
    logic  buf_in_rdy;
    logic  buf_out_vld;
    logic  accept;

    // A byte offered during flush is dropped: it neither enters the buffer nor counts.
    assign buf_in_vld = plain.valid & ~flush;
    assign accept     = buf_in_vld & buf_in_rdy;
    assign mix_dat    = mix_byte(plain.data, key);

    assign plain.ready = buf_in_rdy;
    assign mixed.data  = buf_dat;
    assign mixed.valid = buf_out_vld;

    skid_buffer #(
        .WIDTH (BYTE_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_dat  (mix_dat),
        .in_vld  (buf_in_vld),
        .in_rdy  (buf_in_rdy),
        .out_dat (buf_dat),
        .out_vld (buf_out_vld),
        .out_rdy (mixed.ready)
    );

    // key_load wins over roll, so a byte accepted alongside a load uses the old key and no roll follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key <= KEY_RESET;
        end else if (key_load) begin
            key <= key_in;
        end else if (KEY_ROLL && accept) begin
            key <= key + KEY_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= '0;
        end else if (flush) begin
            byte_count <= '0;
        end else if (accept) begin
            byte_count <= byte_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_key_xor_stage.sv
// Directed bench: a static-key and a rolling-key instance share stimulus and are checked side by side.
module tb_key_xor_stage;
    import crypto_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  flush;
    byte_t key_in;
    logic  key_load;
    byte_t in_data;
    logic  in_valid;
    logic  out_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int checks;
    int errors;

    key_xor_stage_if plain_a ();
    key_xor_stage_if mixed_a ();
    key_xor_stage_if plain_b ();
    key_xor_stage_if mixed_b ();

    assign plain_a.data  = in_data;
    assign plain_a.valid = in_valid;
    assign mixed_a.ready = out_ready;
    assign plain_b.data  = in_data;
    assign plain_b.valid = in_valid;
    assign mixed_b.ready = out_ready;

    key_xor_stage #(
        .KEY_RESET (8'h00),
        .KEY_ROLL  (1'b0),
        .KEY_STEP  (8'h01),
        .COUNT_W   (8)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .key_in     (key_in),
        .key_load   (key_load),
        .plain      (plain_a),
        .mixed      (mixed_a),
        .byte_count (cnt_a)
    );

    key_xor_stage #(
        .KEY_RESET (8'h3E),
        .KEY_ROLL  (1'b1),
        .KEY_STEP  (8'h01),
        .COUNT_W   (8)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .key_in     (key_in),
        .key_load   (key_load),
        .plain      (plain_b),
        .mixed      (mixed_b),
        .byte_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input byte_t k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        key_in    = 8'h00;
        key_load  = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_vld_a", mixed_a.valid, 0);
        chk("rst_dat_a", mixed_a.data, 8'h00);
        chk("rst_rdy_a", plain_a.ready, 1);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_vld_b", mixed_b.valid, 0);
        chk("rst_cnt_b", cnt_b, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // static key A5 ^ 3C
        load_key(8'hA5);
        in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_vld_a", mixed_a.valid, 1);
        chk("t1_dat_a", mixed_a.data, 8'h99);
        chk("t1_cnt_a", cnt_a, 1);
        chk("t1_dat_b", mixed_b.data, 8'h99);
        tick();
        chk("t1_drain_a", mixed_a.valid, 0);

        // rolling key from 10 over three back-to-back zeros
        load_key(8'h10);
        in_data = 8'h00; in_valid = 1'b1;
        tick();
        chk("t2_0_a", mixed_a.data, 8'h10);
        chk("t2_0_b", mixed_b.data, 8'h10);
        tick();
        chk("t2_1_a", mixed_a.data, 8'h10);
        chk("t2_1_b", mixed_b.data, 8'h11);
        tick();
        chk("t2_2_a", mixed_a.data, 8'h10);
        chk("t2_2_b", mixed_b.data, 8'h12);
        chk("t2_2_vld_b", mixed_b.valid, 1);
        in_valid = 1'b0;
        tick();
        chk("t2_idle_b", mixed_b.valid, 0);
        chk("t2_cnt_b", cnt_b, 4);

        // key wraps FF -> 00
        load_key(8'hFF);
        in_data = 8'h00; in_valid = 1'b1;
        tick();
        chk("t3_0_a", mixed_a.data, 8'hFF);
        chk("t3_0_b", mixed_b.data, 8'hFF);
        tick();
        chk("t3_1_a", mixed_a.data, 8'hFF);
        chk("t3_1_b", mixed_b.data, 8'h00);
        in_valid = 1'b0;
        tick();

        // backpressure with skid fill
        load_key(8'h00);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        tick();
        chk("t4_aa_a", mixed_a.data, 8'hAA);
        chk("t4_rdy1_a", plain_a.ready, 1);
        in_data = 8'hBB;
        tick();
        chk("t4_hold1_a", mixed_a.data, 8'hAA);
        chk("t4_rdy0_a", plain_a.ready, 0);
        chk("t4_rdy0_b", plain_b.ready, 0);
        in_data = 8'hCC;
        tick();
        chk("t4_hold2_a", mixed_a.data, 8'hAA);
        chk("t4_hold2_rdy_a", plain_a.ready, 0);
        tick();
        chk("t4_hold3_a", mixed_a.data, 8'hAA);
        chk("t4_hold3_b", mixed_b.data, 8'hAA);
        chk("t4_hold3_vld_a", mixed_a.valid, 1);
        out_ready = 1'b1;
        tick();
        chk("t4_bb_a", mixed_a.data, 8'hBB);
        chk("t4_bb_b", mixed_b.data, 8'hBA);
        chk("t4_rdy_back_a", plain_a.ready, 1);
        tick();
        chk("t4_cc_a", mixed_a.data, 8'hCC);
        chk("t4_cc_b", mixed_b.data, 8'hCE);
        in_valid = 1'b0;
        tick();
        chk("t4_empty_a", mixed_a.valid, 0);
        chk("t4_cnt_a", cnt_a, 9);

        // load coinciding with accept
        load_key(8'h00);
        key_load = 1'b1; key_in = 8'h0F; in_data = 8'h01; in_valid = 1'b1;
        tick();
        key_load = 1'b0;
        chk("t5_old_a", mixed_a.data, 8'h01);
        chk("t5_old_b", mixed_b.data, 8'h01);
        tick();
        chk("t5_new_a", mixed_a.data, 8'h0E);
        chk("t5_new_b", mixed_b.data, 8'h0E);
        in_valid = 1'b0;
        tick();
        chk("t5_cnt_b", cnt_b, 11);

        // flush with both entries full
        load_key(8'h00);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk("t6_full_rdy_a", plain_a.ready, 0);
        chk("t6_full_dat_a", mixed_a.data, 8'h11);
        flush = 1'b1; in_data = 8'h33;
        tick();
        flush = 1'b0;
        chk("t6_fl_vld_a", mixed_a.valid, 0);
        chk("t6_fl_vld_b", mixed_b.valid, 0);
        chk("t6_fl_cnt_a", cnt_a, 0);
        chk("t6_fl_rdy_a", plain_a.ready, 1);
        in_data = 8'h00; out_ready = 1'b1;
        tick();
        chk("t6_keep_a", mixed_a.data, 8'h00);
        chk("t6_keep_b", mixed_b.data, 8'h02);
        chk("t6_keep_cnt_b", cnt_b, 1);
        flush = 1'b1; key_load = 1'b1; key_in = 8'h50; in_data = 8'h44;
        tick();
        flush = 1'b0; key_load = 1'b0;
        chk("t6_drop_cnt_a", cnt_a, 0);
        chk("t6_drop_vld_a", mixed_a.valid, 0);
        in_data = 8'h00;
        tick();
        chk("t6_ld_a", mixed_a.data, 8'h50);
        chk("t6_ld_b", mixed_b.data, 8'h50);
        chk("t6_ld_cnt_a", cnt_a, 1);
        in_valid = 1'b0;
        tick();

        // asynchronous reset mid-stream
        load_key(8'h77);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
        tick();
        in_data = 8'h20;
        tick();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t7_vld_a", mixed_a.valid, 0);
        chk("t7_vld_b", mixed_b.valid, 0);
        chk("t7_rdy_b", plain_b.ready, 1);
        chk("t7_cnt_b", cnt_b, 0);
        #2 rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        tick();
        chk("t7_key_a", mixed_a.data, 8'h00);
        chk("t7_key_b", mixed_b.data, 8'h3E);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
